// File: rtl/psram_ctrl_if.sv
// CPU-side bus of psram_ctrl: single-word request strobe, write data and read return.
// The master drives requests; the slave (the controller) returns data, ready and busy.
interface psram_ctrl_if;
  logic        i_stb;
  logic        i_we;
  logic [23:0] i_addr;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        o_data_ready;
  logic        o_busy;

  modport master (
    output i_stb, i_we, i_addr, i_data,
    input  o_data, o_data_ready, o_busy
  );

  modport slave (
    input  i_stb, i_we, i_addr, i_data,
    output o_data, o_data_ready, o_busy
  );
endinterface

// File: rtl/psram_ctrl.sv
// Octal-SPI SDR PSRAM controller: one 32-bit bus access becomes CMD/ADDR/WAIT/DATA frames.
// Define PSRAM_CTRL_INIT_EN to add the power-up wait and the 0x66/0x99 reset commands.
module psram_ctrl #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned INIT_US   = 150,
  parameter int unsigned READ_WAIT = 6,
  parameter logic [7:0]  CMD_READ  = 8'h0B,
  parameter logic [7:0]  CMD_WRITE = 8'h02
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  psram_ctrl_if.slave bus,
  output logic       o_psram_csn,
  output logic       o_psram_sclk,
  output logic [7:0] o_psram_data,
  output logic       o_psram_oe,
  input  logic [7:0] i_psram_data
);

  if (READ_WAIT < 1 || READ_WAIT > 15 || CLK_HZ / 1_000_000 * INIT_US == 0) begin : g_bad_param
    $error("psram_ctrl: READ_WAIT must be 1..15 and the init wait non-zero");
  end

  typedef enum logic [3:0] {
    ST_INIT_WAIT, ST_INIT_CMD, ST_INIT_GAP, ST_IDLE,
    ST_CMD, ST_ADDR, ST_WAIT, ST_DATA, ST_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;   // 0 = SCLK low half of a bit, 1 = SCLK high half
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;

`ifdef PSRAM_CTRL_INIT_EN
  localparam int unsigned INIT_CYCLES = CLK_HZ / 1_000_000 * INIT_US;
  localparam logic [31:0] INIT_LAST   = 32'(INIT_CYCLES - 1);
  localparam state_e      RESET_STATE = ST_INIT_WAIT;
  logic [31:0] init_cnt_q, init_cnt_d;
  logic        init_sel_q, init_sel_d;   // 0 = 0x66 frame pending, 1 = 0x99 frame
`else
  localparam state_e      RESET_STATE = ST_IDLE;
`endif

  // NOTE: every next-state signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    phase_d = 1'b0;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
`ifdef PSRAM_CTRL_INIT_EN
    init_cnt_d = init_cnt_q;
    init_sel_d = init_sel_q;
`endif
    case (state_q)
`ifdef PSRAM_CTRL_INIT_EN
      ST_INIT_WAIT: begin
        init_cnt_d = init_cnt_q + 32'd1;
        if (init_cnt_q == INIT_LAST) begin
          init_cnt_d = '0;
          state_d    = ST_INIT_CMD;
        end
      end
      ST_INIT_CMD: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d   = '0;
          state_d = ST_INIT_GAP;
        end
      end
      ST_INIT_GAP: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd1) begin
          cnt_d = '0;
          if (init_sel_q) begin
            state_d = ST_IDLE;
          end else begin
            init_sel_d = 1'b1;
            state_d    = ST_INIT_CMD;
          end
        end
      end
`endif
      ST_IDLE: begin
        if (bus.i_stb) begin
          we_d    = bus.i_we;
          addr_d  = bus.i_addr & 24'hFF_FFFC;
          wdata_d = bus.i_data;
          cnt_d   = '0;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        phase_d = ~phase_q;
        if (phase_q) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd2) begin
            cnt_d   = '0;
            state_d = we_q ? ST_DATA : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(READ_WAIT - 1)) begin
            cnt_d   = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 4'd1;
          // Read bytes arrive LSB first; they shift down so the last one lands on top.
          if (!we_q) shift_d = {i_psram_data, shift_q[23:8]};
          if (cnt_q == 4'd3) begin
            cnt_d   = '0;
            state_d = ST_DONE;
            if (!we_q) begin
              rdata_d = {i_psram_data, shift_q};
              ready_d = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd1) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the reset is sampled on the clock edge.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= RESET_STATE;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      shift_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
`ifdef PSRAM_CTRL_INIT_EN
      init_cnt_q <= '0;
      init_sel_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
`ifdef PSRAM_CTRL_INIT_EN
      init_cnt_q <= init_cnt_d;
      init_sel_q <= init_sel_d;
`endif
    end
  end

  logic       frame_active;
  logic       drive;
  logic [7:0] tx_byte;

  always_comb begin
    frame_active = 1'b0;
    drive        = 1'b0;
    tx_byte      = 8'h00;
    case (state_q)
`ifdef PSRAM_CTRL_INIT_EN
      ST_INIT_CMD: begin
        frame_active = 1'b1;
        drive        = 1'b1;
        tx_byte      = init_sel_q ? 8'h99 : 8'h66;
      end
`endif
      ST_CMD: begin
        frame_active = 1'b1;
        drive        = 1'b1;
        tx_byte      = we_q ? CMD_WRITE : CMD_READ;
      end
      ST_ADDR: begin
        frame_active = 1'b1;
        drive        = 1'b1;
        case (cnt_q[1:0])
          2'd0:    tx_byte = addr_q[23:16];
          2'd1:    tx_byte = addr_q[15:8];
          default: tx_byte = addr_q[7:0];
        endcase
      end
      ST_WAIT: frame_active = 1'b1;
      ST_DATA: begin
        frame_active = 1'b1;
        drive        = we_q;
        tx_byte      = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign o_psram_csn      = ~frame_active;
  assign o_psram_sclk     = frame_active & phase_q;
  assign o_psram_oe       = drive;
  assign o_psram_data     = drive ? tx_byte : 8'h00;
  assign bus.o_data       = rdata_q;
  assign bus.o_data_ready = ready_q;
  assign bus.o_busy       = (state_q != ST_IDLE);

endmodule
